jts16_rasterint: RTL and testbench

// - CPU-programmable raster (line) interrupt controller; next generation of the fixed vdump 64/128/192 line_intn decode.
// - NCH compare channels, each a line number plus enable; matches latch per-channel pending bits that drive line_intn.
// - Sits in the video top beside the tilemap timing generator.
// - Consumes vdump; serves the main or sub CPU through a small word-wide register window.

---
 rtl/jts16_rasterint_pkg.sv | 19 +
 rtl/jts16_rasterint_if.sv | 14 +
 rtl/jts16_rasterint_chan.sv | 38 +++
 rtl/jts16_rasterint.sv | 127 ++++++++++++
 tb/tb_jts16_rasterint.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jts16_rasterint_pkg.sv
// Shared constants, channel register layout and address helper for the raster interrupt controller.
package jts16_rint_pkg;

  localparam int RINT_EN_BIT      = 15;
  localparam int RINT_CAP_HIT_MSB = 15;
  localparam int RINT_CAP_HIT_LSB = 12;
  localparam int RINT_VW          = 9;

  // Channel register contents; the line field width fixes the controller's VW
  typedef struct packed {
    logic               en;
    logic [RINT_VW-1:0] line;
  } rint_chan_t;

  function automatic int unsigned rint_status_addr(input int unsigned nch);
    return nch;
  endfunction

endpackage

// File: rtl/jts16_rasterint_if.sv
// Word-wide CPU register window of the raster interrupt controller.
interface jts16_rasterint_if #(
  parameter int AW = 3
);
  logic          cpu_cs;
  logic [AW-1:0] cpu_addr;
  logic          cpu_rnw;
  logic [1:0]    cpu_dswn;
  logic [15:0]   cpu_dout;
  logic [15:0]   cpu_din;

  modport master (output cpu_cs, cpu_addr, cpu_rnw, cpu_dswn, cpu_dout, input cpu_din);
  modport slave  (input cpu_cs, cpu_addr, cpu_rnw, cpu_dswn, cpu_dout, output cpu_din);
endinterface

// File: rtl/jts16_rasterint_chan.sv
// One raster compare channel: byte-writable line/enable register and the new-line match.
module jts16_rasterint_chan
  import jts16_rint_pkg::*;
#(
  parameter int           VW        = RINT_VW,
  parameter logic [VW-1:0] INIT_LINE = '0,
  parameter logic          INIT_EN   = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [1:0]    dswn,
  input  logic [15:0]   dout,
  input  logic          newline,
  input  logic [VW-1:0] vdump,
  output rint_chan_t    chan,
  output logic          match
);

  logic unused_dout;
  assign unused_dout = ^dout[RINT_EN_BIT-1:VW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chan.en   <= INIT_EN;
      chan.line <= INIT_LINE;
    end else if (wr) begin
      if (!dswn[1]) chan.en <= dout[RINT_EN_BIT];
      for (int unsigned b = 0; b < VW; b++) begin
        if (!dswn[b/8]) chan.line[b] <= dout[b];
      end
    end
  end

  // Compares against the register before any same-clk write lands
  assign match = newline & chan.en & (chan.line == vdump);

endmodule

// File: rtl/jts16_rasterint.sv
// Programmable raster line interrupt controller with NCH compare channels.
// Define JTS16_RINT_CAPTURE_EN to add the hit-count / last-line capture register at addr NCH+1.
module jts16_rasterint
  import jts16_rint_pkg::*;
#(
  parameter int                NCH        = 4,
  parameter int                VW         = RINT_VW,
  parameter logic [NCH*VW-1:0] INIT_LINES = {9'd0, 9'd192, 9'd128, 9'd64},
  parameter logic [NCH-1:0]    INIT_EN    = 4'b0111,
  parameter int                PULSE_LEN  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pxl_cen,
  input  logic [VW-1:0]      vdump,
  jts16_rasterint_if.slave   cpu,
  input  logic               int_ack,
  output logic               line_intn
);

  localparam int AW   = $clog2(NCH+2);
  localparam int STAT = rint_status_addr(NCH);

  logic [VW-1:0]  vdump_l;
  logic           newline;
  logic           wr_en;
  logic [NCH-1:0] match;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] w1c;
  logic [NCH-1:0] clr;
  logic           pulse_clr;
  logic [15:0]    rdata;
  rint_chan_t     chans [NCH];

  assign newline = vdump != vdump_l;
  assign wr_en   = cpu.cpu_cs & ~cpu.cpu_rnw;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    jts16_rasterint_chan #(
      .VW        (VW),
      .INIT_LINE (INIT_LINES[gi*VW +: VW]),
      .INIT_EN   (INIT_EN[gi])
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr      (wr_en && (cpu.cpu_addr == AW'(gi))),
      .dswn    (cpu.cpu_dswn),
      .dout    (cpu.cpu_dout),
      .newline (newline),
      .vdump   (vdump),
      .chan    (chans[gi]),
      .match   (match[gi])
    );
  end

  assign w1c = (wr_en && cpu.cpu_addr == AW'(STAT) && !cpu.cpu_dswn[0]) ?
               cpu.cpu_dout[NCH-1:0] : '0;

  if (PULSE_LEN > 0) begin : g_pulse
    localparam int CW = $clog2(PULSE_LEN+1);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       cnt <= '0;
      else if (|match)                  cnt <= CW'(PULSE_LEN);
      else if (pxl_cen && cnt != '0)    cnt <= cnt - CW'(1);
    end
    // A same-clk retrigger reloads instead of expiring
    assign pulse_clr = pxl_cen && (cnt == CW'(1)) && !(|match);
  end else begin : g_hold
    logic unused_pxl_cen;
    assign unused_pxl_cen = pxl_cen;
    assign pulse_clr      = 1'b0;
  end

  assign clr = {NCH{int_ack | pulse_clr}} | w1c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vdump_l   <= '0;
      pending   <= '0;
      line_intn <= 1'b1;
    end else begin
      vdump_l   <= vdump;
      pending   <= (pending & ~clr) | match;
      line_intn <= ~|pending;
    end
  end

`ifdef JTS16_RINT_CAPTURE_EN
  logic [3:0]    hit_cnt;
  logic [VW-1:0] cap_line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      cap_line <= '0;
    end else if (|match) begin
      hit_cnt  <= hit_cnt + 4'd1;
      cap_line <= vdump;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (cpu.cpu_addr == AW'(i)) begin
        rdata[RINT_EN_BIT] = chans[i].en;
        rdata[VW-1:0]      = chans[i].line;
      end
    end
    if (cpu.cpu_addr == AW'(STAT)) rdata[NCH-1:0] = pending;
`ifdef JTS16_RINT_CAPTURE_EN
    if (cpu.cpu_addr == AW'(NCH+1)) begin
      rdata[RINT_CAP_HIT_MSB:RINT_CAP_HIT_LSB] = hit_cnt;
      rdata[VW-1:0]                            = cap_line;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cpu.cpu_din <= '0;
    else if (cpu.cpu_cs && cpu.cpu_rnw)  cpu.cpu_din <= rdata;
  end

endmodule

// File: tb/tb_jts16_rasterint.sv
// Directed bench for jts16_rasterint: default instance plus a PULSE_LEN=3 instance.
module tb_jts16_rasterint;

  localparam int AW = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pxl_cen;
  logic       int_ack;
  logic [8:0] vdump;
  logic [8:0] vdump_p;
  logic       line_intn;
  logic       line_intn_p;
  logic [15:0] rd;
  int         n_tests = 0;
  int         n_fail  = 0;

  jts16_rasterint_if #(.AW(AW)) bus ();
  jts16_rasterint_if #(.AW(AW)) bus_p ();

  always #5 clk = ~clk;

  jts16_rasterint dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pxl_cen   (pxl_cen),
    .vdump     (vdump),
    .cpu       (bus),
    .int_ack   (int_ack),
    .line_intn (line_intn)
  );

  jts16_rasterint #(.PULSE_LEN(3)) dut_p (
    .clk       (clk),
    .rst_n     (rst_n),
    .pxl_cen   (pxl_cen),
    .vdump     (vdump_p),
    .cpu       (bus_p),
    .int_ack   (int_ack),
    .line_intn (line_intn_p)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle;
    bus.cpu_cs = 1'b0;   bus.cpu_rnw = 1'b1;   bus.cpu_addr = '0;
    bus.cpu_dswn = 2'b11; bus.cpu_dout = '0;
    bus_p.cpu_cs = 1'b0; bus_p.cpu_rnw = 1'b1; bus_p.cpu_addr = '0;
    bus_p.cpu_dswn = 2'b11; bus_p.cpu_dout = '0;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] ds);
    bus.cpu_cs = 1'b1; bus.cpu_rnw = 1'b0; bus.cpu_addr = a;
    bus.cpu_dout = d;  bus.cpu_dswn = ds;
    tick;
    bus_idle;
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, output logic [15:0] d);
    bus.cpu_cs = 1'b1; bus.cpu_rnw = 1'b1; bus.cpu_addr = a;
    tick;
    bus_idle;
    d = bus.cpu_din;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0; pxl_cen = 1'b0; int_ack = 1'b0;
    vdump = '0; vdump_p = '0;
    bus_idle;
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    logic [15:0] exp_ch [4];
    exp_ch[0] = 16'h8040; exp_ch[1] = 16'h8080; exp_ch[2] = 16'h80C0; exp_ch[3] = 16'h0000;
    apply_reset;
    n_tests++;
    if (line_intn !== 1'b1) begin n_fail++; $display("FAIL reset_intn got=%b exp=1", line_intn); end
    n_tests++;
    if (line_intn_p !== 1'b1) begin n_fail++; $display("FAIL reset_intn_p got=%b exp=1", line_intn_p); end
    n_tests++;
    if (bus.cpu_din !== 16'h0000) begin n_fail++; $display("FAIL reset_din got=%h exp=0000", bus.cpu_din); end
    for (int i = 0; i < 4; i++) begin
      cpu_read(AW'(i), rd);
      n_tests++;
      if (rd !== exp_ch[i]) begin n_fail++; $display("FAIL reset_ch%0d got=%h exp=%h", i, rd, exp_ch[i]); end
    end
    cpu_read(3'd4, rd);
    n_tests++;
    if (rd !== 16'h0000) begin n_fail++; $display("FAIL reset_status got=%h exp=0000", rd); end
  endtask

  task automatic test_frame;
    apply_reset;
    for (int v = 1; v <= 261; v++) begin
      vdump = 9'(v);
      tick;
      n_tests++;
      if (line_intn !== 1'b1) begin n_fail++; $display("FAIL frame_lat1 line=%0d got=%b exp=1", v, line_intn); end
      tick;
      if (v == 64 || v == 128 || v == 192) begin
        n_tests++;
        if (line_intn !== 1'b0) begin n_fail++; $display("FAIL frame_fall line=%0d got=%b exp=0", v, line_intn); end
        tick; tick; tick;
        n_tests++;
        if (line_intn !== 1'b0) begin n_fail++; $display("FAIL frame_hold line=%0d got=%b exp=0", v, line_intn); end
        int_ack = 1'b1;
        tick;
        int_ack = 1'b0;
        n_tests++;
        if (line_intn !== 1'b0) begin n_fail++; $display("FAIL frame_ack0 line=%0d got=%b exp=0", v, line_intn); end
        tick;
        n_tests++;
        if (line_intn !== 1'b1) begin n_fail++; $display("FAIL frame_ack1 line=%0d got=%b exp=1", v, line_intn); end
      end else begin
        n_tests++;
        if (line_intn !== 1'b1) begin n_fail++; $display("FAIL frame_idle line=%0d got=%b exp=1", v, line_intn); end
      end
    end
    vdump = '0;
    tick; tick;
    n_tests++;
    if (line_intn !== 1'b1) begin n_fail++; $display("FAIL frame_wrap got=%b exp=1", line_intn); end
  endtask

`ifdef JTS16_RINT_CAPTURE_EN
  task automatic test_capture;
    cpu_read(3'd5, rd);
    n_tests++;
    if (rd !== 16'h30C0) begin n_fail++; $display("FAIL capture_frame got=%h exp=30C0", rd); end
  endtask
`endif

  task automatic test_chan_write;
    apply_reset;
    cpu_write(3'd3, 16'h800A, 2'b00);
    cpu_read(3'd3, rd);
    n_tests++;
    if (rd !== 16'h800A) begin n_fail++; $display("FAIL chw_readback got=%h exp=800A", rd); end
    vdump = 9'd9; tick; tick;
    n_tests++;
    if (line_intn !== 1'b1) begin n_fail++; $display("FAIL chw_line9 got=%b exp=1", line_intn); end
    vdump = 9'd10; tick; tick;
    n_tests++;
    if (line_intn !== 1'b0) begin n_fail++; $display("FAIL chw_line10 got=%b exp=0", line_intn); end
    cpu_read(3'd4, rd);
    n_tests++;
    if (rd !== 16'h0008) begin n_fail++; $display("FAIL chw_status got=%h exp=0008", rd); end
    cpu_write(3'd4, 16'h0008, 2'b00);
    n_tests++;
    if (line_intn !== 1'b0) begin n_fail++; $display("FAIL chw_w1c_lat got=%b exp=0", line_intn); end
    tick;
    n_tests++;
    if (line_intn !== 1'b1) begin n_fail++; $display("FAIL chw_w1c got=%b exp=1", line_intn); end
  endtask

  task automatic test_byte_write;
    apply_reset;
    cpu_write(3'd0, 16'h0000, 2'b10);
    cpu_read(3'd0, rd);
    n_tests++;
    if (rd !== 16'h8000) begin n_fail++; $display("FAIL bw_low got=%h exp=8000", rd); end
    vdump = 9'd63; tick; tick;
    vdump = 9'd64; tick; tick;
    n_tests++;
    if (line_intn !== 1'b1) begin n_fail++; $display("FAIL bw_low_nomatch got=%b exp=1", line_intn); end
    cpu_write(3'd0, 16'h0040, 2'b10);
    cpu_read(3'd0, rd);
    n_tests++;
    if (rd !== 16'h8040) begin n_fail++; $display("FAIL bw_low_restore got=%h exp=8040", rd); end
    cpu_write(3'd0, 16'h0000, 2'b01);
    cpu_read(3'd0, rd);
    n_tests++;
    if (rd !== 16'h0040) begin n_fail++; $display("FAIL bw_high got=%h exp=0040", rd); end
    vdump = 9'd63; tick; tick;
    vdump = 9'd64; tick; tick;
    n_tests++;
    if (line_intn !== 1'b1) begin n_fail++; $display("FAIL bw_disabled got=%b exp=1", line_intn); end
    cpu_write(3'd1, 16'hFFFF, 2'b00);
    cpu_read(3'd1, rd);
    n_tests++;
    if (rd !== 16'h81FF) begin n_fail++; $display("FAIL bw_reserved got=%h exp=81FF", rd); end
    cpu_write(3'd6, 16'hFFFF, 2'b00);
    cpu_read(3'd6, rd);
    n_tests++;
    if (rd !== 16'h0000) begin n_fail++; $display("FAIL bw_unmapped6 got=%h exp=0000", rd); end
    cpu_read(3'd7, rd);
    n_tests++;
    if (rd !== 16'h0000) begin n_fail++; $display("FAIL bw_unmapped7 got=%h exp=0000", rd); end
`ifndef JTS16_RINT_CAPTURE_EN
    cpu_read(3'd5, rd);
    n_tests++;
    if (rd !== 16'h0000) begin n_fail++; $display("FAIL bw_unmapped5 got=%h exp=0000", rd); end
`endif
  endtask

  task automatic test_ack_collision;
    apply_reset;
    vdump = 9'd63;  tick; tick;
    vdump = 9'd64;  tick; tick;
    vdump = 9'd127; tick; tick;
    vdump = 9'd128;
    int_ack = 1'b1;
    tick;
    int_ack = 1'b0;
    tick;
    n_tests++;
    if (line_intn !== 1'b0) begin n_fail++; $display("FAIL ack_set_wins got=%b exp=0", line_intn); end
    cpu_read(3'd4, rd);
    n_tests++;
    if (rd !== 16'h0002) begin n_fail++; $display("FAIL ack_status got=%h exp=0002", rd); end
    cpu_write(3'd4, 16'h000F, 2'b01);
    cpu_read(3'd4, rd);
    n_tests++;
    if (rd !== 16'h0002) begin n_fail++; $display("FAIL w1c_gated got=%h exp=0002", rd); end
    cpu_write(3'd4, 16'h0001, 2'b00);
    cpu_read(3'd4, rd);
    n_tests++;
    if (rd !== 16'h0002) begin n_fail++; $display("FAIL w1c_other got=%h exp=0002", rd); end
    cpu_write(3'd4, 16'h0002, 2'b00);
    tick;
    n_tests++;
    if (line_intn !== 1'b1) begin n_fail++; $display("FAIL w1c_clear got=%b exp=1", line_intn); end
  endtask

  task automatic test_write_on_newline;
    apply_reset;
    vdump = 9'd63; tick; tick;
    vdump = 9'd64;
    bus.cpu_cs = 1'b1; bus.cpu_rnw = 1'b0; bus.cpu_addr = 3'd0;
    bus.cpu_dout = 16'h8041; bus.cpu_dswn = 2'b00;
    tick;
    bus_idle;
    tick;
    n_tests++;
    if (line_intn !== 1'b0) begin n_fail++; $display("FAIL won_old_value got=%b exp=0", line_intn); end
    cpu_read(3'd4, rd);
    n_tests++;
    if (rd !== 16'h0001) begin n_fail++; $display("FAIL won_pending_kept got=%h exp=0001", rd); end
    cpu_read(3'd0, rd);
    n_tests++;
    if (rd !== 16'h8041) begin n_fail++; $display("FAIL won_readback got=%h exp=8041", rd); end
    int_ack = 1'b1; tick; int_ack = 1'b0;
    vdump = 9'd65; tick; tick;
    n_tests++;
    if (line_intn !== 1'b0) begin n_fail++; $display("FAIL won_new_value got=%b exp=0", line_intn); end
  endtask

  task automatic test_wrap;
    apply_reset;
    cpu_write(3'd3, 16'h8000, 2'b00);
    vdump = 9'd261; tick; tick;
    n_tests++;
    if (line_intn !== 1'b1) begin n_fail++; $display("FAIL wrap_261 got=%b exp=1", line_intn); end
    vdump = 9'd0; tick; tick;
    n_tests++;
    if (line_intn !== 1'b0) begin n_fail++; $display("FAIL wrap_0 got=%b exp=0", line_intn); end
    cpu_read(3'd4, rd);
    n_tests++;
    if (rd !== 16'h0008) begin n_fail++; $display("FAIL wrap_status got=%h exp=0008", rd); end
  endtask

  task automatic pulse_run(input bit retrig, output logic intn0, output int low);
    bit done;
    pxl_cen = 1'b0;
    vdump_p = 9'd191; tick; tick;
    vdump_p = 9'd192;
    tick;
    intn0 = line_intn_p;
    low  = 0;
    done = 1'b0;
    for (int i = 1; i <= 40 && !done; i++) begin
      pxl_cen = (i % 2 == 0);
      if (retrig && i == 3) vdump_p = 9'd193;
      tick;
      if (line_intn_p === 1'b0) low++;
      else done = 1'b1;
    end
    pxl_cen = 1'b0;
  endtask

  task automatic test_pulse;
    logic intn0;
    int   low;
    apply_reset;
    pulse_run(1'b0, intn0, low);
    n_tests++;
    if (intn0 !== 1'b1) begin n_fail++; $display("FAIL pulse_lat got=%b exp=1", intn0); end
    n_tests++;
    if (low != 6) begin n_fail++; $display("FAIL pulse_len got=%0d exp=6", low); end
    bus_p.cpu_cs = 1'b1; bus_p.cpu_rnw = 1'b0; bus_p.cpu_addr = 3'd3;
    bus_p.cpu_dout = 16'h80C1; bus_p.cpu_dswn = 2'b00;
    tick;
    bus_idle;
    pulse_run(1'b1, intn0, low);
    n_tests++;
    if (low != 8) begin n_fail++; $display("FAIL pulse_retrig got=%0d exp=8", low); end
  endtask

  task automatic test_async_reset;
    apply_reset;
    vdump = 9'd63; vdump_p = 9'd191; tick; tick;
    vdump = 9'd64; vdump_p = 9'd192; tick; tick;
    n_tests++;
    if (line_intn !== 1'b0 || line_intn_p !== 1'b0) begin
      n_fail++; $display("FAIL arst_pre got=%b%b exp=00", line_intn, line_intn_p);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (line_intn !== 1'b1) begin n_fail++; $display("FAIL arst_intn got=%b exp=1", line_intn); end
    n_tests++;
    if (line_intn_p !== 1'b1) begin n_fail++; $display("FAIL arst_intn_p got=%b exp=1", line_intn_p); end
    vdump = '0; vdump_p = '0;
    tick;
    rst_n = 1'b1;
    tick;
    cpu_read(3'd4, rd);
    n_tests++;
    if (rd !== 16'h0000) begin n_fail++; $display("FAIL arst_status got=%h exp=0000", rd); end
`ifdef JTS16_RINT_CAPTURE_EN
    cpu_read(3'd5, rd);
    n_tests++;
    if (rd !== 16'h0000) begin n_fail++; $display("FAIL arst_capture got=%h exp=0000", rd); end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_frame;
`ifdef JTS16_RINT_CAPTURE_EN
    test_capture;
`endif
    test_chan_write;
    test_byte_write;
    test_ack_collision;
    test_write_on_newline;
    test_wrap;
    test_pulse;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
